// File: rtl/instance_id_checker_if.sv
// Leaf instance-identity report beat: valid/ready handshake carrying the ID and p1 value.
interface instance_id_checker_if;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [31:0] rpt_id;
  logic [31:0] rpt_p1;

  modport master (output rpt_valid, rpt_id, rpt_p1, input rpt_ready);
  modport slave  (input rpt_valid, rpt_id, rpt_p1, output rpt_ready);
endinterface

// File: rtl/instance_id_checker.sv
// Scoreboards leaf identity reports against IDs 0..N_IDS-1: flags duplicate,
// out-of-range and missing IDs, sums p1 and issues a pass/fail verdict.
module instance_id_checker #(
  parameter int N_IDS = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 finish,
  instance_id_checker_if.slave rpt,
  output logic [CNT_W-1:0]     rcv_cnt,
  output logic [CNT_W-1:0]     dup_cnt,
  output logic [CNT_W-1:0]     oor_cnt,
  output logic [CNT_W-1:0]     miss_cnt,
  output logic [31:0]          first_dup,
  output logic [31:0]          first_miss,
  output logic [31:0]          p1_sum,
  output logic                 done,
  output logic                 pass
);
  localparam int IDX_W = (N_IDS > 1) ? $clog2(N_IDS) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] SCAN    = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [IDX_W-1:0] K_LAST  = IDX_W'(N_IDS - 1);

  logic [1:0]       state;
  logic [N_IDS-1:0] seen;
  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] id_idx;
  logic             in_range;
  logic             clr;

  assign rpt.rpt_ready = (state == COLLECT);
  assign in_range      = rpt.rpt_id < 32'(N_IDS);
  assign id_idx        = rpt.rpt_id[IDX_W-1:0];
  // start is ignored only while scanning; everywhere else it clears and (re)enters COLLECT
  assign clr           = start && (state != SCAN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      seen       <= '0;
      k          <= '0;
      rcv_cnt    <= '0;
      dup_cnt    <= '0;
      oor_cnt    <= '0;
      miss_cnt   <= '0;
      first_dup  <= '1;
      first_miss <= '1;
      p1_sum     <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else if (clr) begin
      state      <= COLLECT;
      seen       <= '0;
      k          <= '0;
      rcv_cnt    <= '0;
      dup_cnt    <= '0;
      oor_cnt    <= '0;
      miss_cnt   <= '0;
      first_dup  <= '1;
      first_miss <= '1;
      p1_sum     <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          // a beat arriving with finish is scored before the scan begins
          if (rpt.rpt_valid) begin
            if (!in_range) begin
              if (oor_cnt != CNT_MAX) oor_cnt <= oor_cnt + CNT_ONE;
            end else if (seen[id_idx]) begin
              if (dup_cnt != CNT_MAX) dup_cnt <= dup_cnt + CNT_ONE;
              if (first_dup == '1) first_dup <= rpt.rpt_id;
            end else begin
              seen[id_idx] <= 1'b1;
              if (rcv_cnt != CNT_MAX) rcv_cnt <= rcv_cnt + CNT_ONE;
              p1_sum <= p1_sum + rpt.rpt_p1;
            end
          end
          if (finish) begin
            state <= SCAN;
            k     <= '0;
          end
        end
        SCAN: begin
          if (!seen[k]) begin
            if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_ONE;
            if (first_miss == '1) first_miss <= 32'(k);
          end
          if (k == K_LAST) begin
            state <= DONE;
            done  <= 1'b1;
            // the last index's miss has not landed in miss_cnt yet
            pass  <= (miss_cnt == '0) && seen[k] && (dup_cnt == '0) && (oor_cnt == '0);
          end else begin
            k <= k + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instance_id_checker.sv
// Randomised self-checking bench for instance_id_checker with a set-based reference model.
module tb_instance_id_checker;
  localparam int N    = 32;
  localparam int CW   = 16;
  localparam int SMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, finish = 1'b0;
  logic start4 = 1'b0, finish4 = 1'b0;

  instance_id_checker_if bus ();
  instance_id_checker_if bus4 ();

  logic [CW-1:0] rcv_cnt, dup_cnt, oor_cnt, miss_cnt;
  logic [31:0]   first_dup, first_miss, p1_sum;
  logic          done, pass;
  logic [3:0]    rcv4, dup4, oor4, miss4;
  logic [31:0]   fdup4, fmiss4, sum4;
  logic          done4, pass4;

  instance_id_checker #(.N_IDS(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .rpt(bus.slave),
    .rcv_cnt(rcv_cnt), .dup_cnt(dup_cnt), .oor_cnt(oor_cnt), .miss_cnt(miss_cnt),
    .first_dup(first_dup), .first_miss(first_miss), .p1_sum(p1_sum),
    .done(done), .pass(pass));

  instance_id_checker #(.N_IDS(N), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .finish(finish4), .rpt(bus4.slave),
    .rcv_cnt(rcv4), .dup_cnt(dup4), .oor_cnt(oor4), .miss_cnt(miss4),
    .first_dup(fdup4), .first_miss(fmiss4), .p1_sum(sum4),
    .done(done4), .pass(pass4));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a set of seen IDs plus raw counts; outputs derived by saturation.
  bit          m_seen [N];
  int          m_rcv, m_dup, m_oor, m_miss, m_left;
  logic [31:0] m_sum, m_fdup, m_fmiss;
  bit          m_coll, m_scan, m_done, m_pass;

  function automatic int sat(input int v);
    return (v > SMAX) ? SMAX : v;
  endfunction

  task automatic m_reset();
    foreach (m_seen[i]) m_seen[i] = 1'b0;
    m_rcv = 0; m_dup = 0; m_oor = 0; m_miss = 0; m_left = 0;
    m_sum = '0; m_fdup = '1; m_fmiss = '1;
    m_coll = 0; m_scan = 0; m_done = 0; m_pass = 0;
  endtask

  initial m_reset();

  always @(posedge clk) begin
    if (rst) m_reset();
    else if (start && !m_scan) begin
      m_reset();
      m_coll = 1;
    end else if (m_scan) begin
      m_left--;
      if (m_left == 0) begin
        m_scan = 0;
        m_done = 1;
        m_pass = (m_miss == 0) && (m_dup == 0) && (m_oor == 0);
      end
    end else if (m_coll) begin
      if (bus.rpt_valid) begin
        if (bus.rpt_id >= 32'(N)) m_oor++;
        else if (m_seen[bus.rpt_id]) begin
          m_dup++;
          if (m_fdup === 32'hFFFF_FFFF) m_fdup = bus.rpt_id;
        end else begin
          m_seen[bus.rpt_id] = 1'b1;
          m_rcv++;
          m_sum = m_sum + bus.rpt_p1;
        end
      end
      if (finish) begin
        m_coll = 0;
        m_scan = 1;
        m_left = N;
        for (int i = 0; i < N; i++)
          if (!m_seen[i]) begin
            m_miss++;
            if (m_fmiss === 32'hFFFF_FFFF) m_fmiss = 32'(i);
          end
      end
    end
  end

  always @(negedge clk) begin
    chk("rpt_ready", bus.rpt_ready, m_coll);
    chk("rcv_cnt", rcv_cnt, sat(m_rcv));
    chk("dup_cnt", dup_cnt, sat(m_dup));
    chk("oor_cnt", oor_cnt, sat(m_oor));
    chk("p1_sum", p1_sum, m_sum);
    chk("first_dup", first_dup, m_fdup);
    chk("done", done, m_done);
    if (m_done) begin
      chk("miss_cnt", miss_cnt, sat(m_miss));
      chk("first_miss", first_miss, m_fmiss);
      chk("pass", pass, m_pass);
    end else begin
      chk("pass_early", pass, 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] id, input logic [31:0] p1, input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0) begin
      bus.rpt_valid = 1'b0;
      bus.rpt_id    = $urandom;
      tick();
    end
    bus.rpt_valid = 1'b1;
    bus.rpt_id    = id;
    bus.rpt_p1    = p1;
    tick();
    bus.rpt_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_finish();
    finish = 1'b1; tick(); finish = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got %0d cycles without done", cyc);
    end
  endtask

  task automatic scan_beats();
    bus.rpt_valid = 1'b1;
    bus.rpt_id    = 32'd9;
    bus.rpt_p1    = 32'h1234;
    repeat (4) tick();
    chk("scan_ready_low", bus.rpt_ready, 1'b0);
    bus.rpt_valid = 1'b0;
  endtask

  int lat;

  initial begin
    bus.rpt_valid = 1'b0; bus.rpt_id = '0; bus.rpt_p1 = '0;
    bus4.rpt_valid = 1'b0; bus4.rpt_id = '0; bus4.rpt_p1 = '0;
    repeat (2) tick();
    chk("rst_ready", bus.rpt_ready, 1'b0);
    chk("rst_rcv", rcv_cnt, 32'd0);
    chk("rst_first_dup", first_dup, 32'hFFFF_FFFF);
    chk("rst_first_miss", first_miss, 32'hFFFF_FFFF);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    tick();

    // Clean set; valid held before start, ID 31 rides with finish
    bus.rpt_valid = 1'b1; bus.rpt_id = 32'd0; bus.rpt_p1 = 32'd1;
    repeat (3) tick();
    chk("idle_rcv", rcv_cnt, 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_cycle_rcv", rcv_cnt, 32'd0);
    tick();
    for (int i = 1; i < 31; i++) beat(32'(i), 32'(i + 1), 1'b0);
    bus.rpt_valid = 1'b1; bus.rpt_id = 32'd31; bus.rpt_p1 = 32'd32;
    finish = 1'b1; tick(); finish = 1'b0; bus.rpt_valid = 1'b0;
    wait_done(lat);
    chk("clean_latency", 32'(lat), 32'd33);
    chk("clean_rcv", rcv_cnt, 32'd32);
    chk("clean_sum", p1_sum, 32'd528);
    chk("clean_miss", miss_cnt, 32'd0);
    chk("clean_first_miss", first_miss, 32'hFFFF_FFFF);
    chk("clean_pass", pass, 1'b1);

    // Duplicate of 5, ID 7 missing
    do_start();
    for (int i = 0; i < N; i++) begin
      if (i != 7) beat(32'(i), 32'(i + 1), 1'b1);
      if (i == 20) beat(32'd5, 32'd99, 1'b1);
    end
    do_finish();
    wait_done(lat);
    chk("dup_rcv", rcv_cnt, 32'd31);
    chk("dup_dup", dup_cnt, 32'd1);
    chk("dup_first", first_dup, 32'd5);
    chk("dup_miss", miss_cnt, 32'd1);
    chk("dup_first_miss", first_miss, 32'd7);
    chk("dup_sum", p1_sum, 32'd520);
    chk("dup_pass", pass, 1'b0);

    // Out-of-range plus beats offered during the scan
    do_start();
    for (int i = 0; i < N; i++) begin
      beat(32'(i), $urandom, 1'b1);
      if (i == 4) beat(32'd32, $urandom, 1'b1);
      if (i == 17) beat(32'hFFFF_FFFF, $urandom, 1'b1);
    end
    do_finish();
    scan_beats();
    chk("scan_rcv_hold", rcv_cnt, 32'd32);
    wait_done(lat);
    chk("oor_oor", oor_cnt, 32'd2);
    chk("oor_rcv", rcv_cnt, 32'd32);
    chk("oor_miss", miss_cnt, 32'd0);
    chk("oor_pass", pass, 1'b0);

    // Restart mid-collect (start beats finish and a beat in the same cycle)
    do_start();
    for (int i = 0; i < 10; i++) beat(32'(i), 32'(i), 1'b1);
    bus.rpt_valid = 1'b1; bus.rpt_id = 32'd10;
    start = 1'b1; finish = 1'b1; tick(); start = 1'b0; finish = 1'b0;
    bus.rpt_valid = 1'b0;
    chk("restart_rcv", rcv_cnt, 32'd0);
    chk("restart_ready", bus.rpt_ready, 1'b1);
    for (int i = N - 1; i >= 0; i--) beat(32'(i), $urandom, 1'b1);
    do_finish();
    wait_done(lat);
    chk("restart_pass", pass, 1'b1);

    // Random streams
    for (int r = 0; r < 6; r++) begin
      do_start();
      for (int b = 0; b < int'($urandom_range(10, 70)); b++)
        beat(($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, N + 3)),
             $urandom, 1'b1);
      do_finish();
      wait_done(lat);
    end

    // Asynchronous reset at scan index 12
    do_start();
    for (int i = 0; i < 20; i++) beat(32'($urandom_range(0, N - 1)), $urandom, 1'b1);
    do_finish();
    repeat (12) tick();
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    chk("arst_ready", bus.rpt_ready, 1'b0);
    chk("arst_rcv", rcv_cnt, 32'd0);
    chk("arst_dup", dup_cnt, 32'd0);
    chk("arst_miss", miss_cnt, 32'd0);
    chk("arst_sum", p1_sum, 32'd0);
    chk("arst_first_dup", first_dup, 32'hFFFF_FFFF);
    chk("arst_first_miss", first_miss, 32'hFFFF_FFFF);
    chk("arst_done", done, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Saturation on a 4-bit counter instance
    start4 = 1'b1; tick(); start4 = 1'b0;
    bus4.rpt_valid = 1'b1; bus4.rpt_id = 32'd0; bus4.rpt_p1 = 32'd3;
    repeat (20) tick();
    bus4.rpt_valid = 1'b0;
    finish4 = 1'b1; tick(); finish4 = 1'b0;
    for (int c = 0; c < 100 && !done4; c++) tick();
    chk("sat_done", done4, 1'b1);
    chk("sat_dup", dup4, 32'd15);
    chk("sat_rcv", rcv4, 32'd1);
    chk("sat_miss", miss4, 32'd15);
    chk("sat_sum", sum4, 32'd3);
    chk("sat_pass", pass4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
